// File: rtl/cw305_bus_pkg.sv
// Shared types and helpers for the CW305 USB register-bus initiator.
package cw305_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WDATA,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD
  } bus_state_t;

  localparam int DEF_ADDR_WIDTH    = 21;
  localparam int DEF_BYTECNT_SIZE  = 8;
  localparam int DEF_SETUP_CYCLES  = 1;
  localparam int DEF_STROBE_CYCLES = 3;
  localparam int DEF_HOLD_CYCLES   = 1;

  // Bus address is the register number with the byte index in its low bits.
  // Computed wide; the caller truncates to its own address width.
  function automatic logic [63:0] bus_addr(input logic [63:0] reg_addr,
                                           input logic [63:0] bytecnt,
                                           input int          bytecnt_size);
    return (reg_addr << bytecnt_size) | bytecnt;
  endfunction

endpackage

// File: rtl/cw305_bus_phase_timer.sv
// Down-counter shared by the setup, strobe and hold phases.
module cw305_bus_phase_timer #(
  parameter int pWIDTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [pWIDTH-1:0] load_val,
  output logic              expired
);

  logic [pWIDTH-1:0] count_reg;

  // Load N-1 on phase entry, so the phase lasts N cycles until the count hits zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_val;
    end else if (count_reg != '0) begin
      count_reg <= count_reg - pWIDTH'(1);
    end
  end

  assign expired = (count_reg == '0);

endmodule

// File: rtl/cw305_usb_bus_master.sv
// Turns byte-burst read/write commands into timed CW305 parallel-bus cycles.
module cw305_usb_bus_master
  import cw305_bus_pkg::*;
#(
  parameter int pADDR_WIDTH    = DEF_ADDR_WIDTH,
  parameter int pBYTECNT_SIZE  = DEF_BYTECNT_SIZE,
  parameter int pSETUP_CYCLES  = DEF_SETUP_CYCLES,
  parameter int pSTROBE_CYCLES = DEF_STROBE_CYCLES,
  parameter int pHOLD_CYCLES   = DEF_HOLD_CYCLES
) (
  input  logic                                 usb_clk,
  input  logic                                 reset_i,
  input  logic                                 cmd_valid,
  output logic                                 cmd_ready,
  input  logic                                 cmd_write,
  input  logic [pADDR_WIDTH-pBYTECNT_SIZE-1:0] cmd_reg,
  input  logic [pBYTECNT_SIZE-1:0]             cmd_len,
  input  logic                                 wdata_valid,
  output logic                                 wdata_ready,
  input  logic [7:0]                           wdata,
  output logic                                 rdata_valid,
  input  logic                                 rdata_ready,
  output logic [7:0]                           rdata,
  output logic                                 done,
  output logic [pADDR_WIDTH-1:0]               usb_addr,
  output logic [7:0]                           usb_dout,
  output logic                                 usb_data_oe,
  input  logic [7:0]                           usb_din,
  output logic                                 usb_rdn,
  output logic                                 usb_wrn,
  output logic                                 usb_cen
);

  localparam int REG_W   = pADDR_WIDTH - pBYTECNT_SIZE;
  localparam int MAX_SS  = (pSETUP_CYCLES > pSTROBE_CYCLES) ? pSETUP_CYCLES : pSTROBE_CYCLES;
  localparam int MAX_CYC = (MAX_SS > pHOLD_CYCLES) ? MAX_SS : pHOLD_CYCLES;
  localparam int TW      = $clog2(MAX_CYC + 1);

  bus_state_t               state_reg, state_next;
  logic                     write_reg, write_next;
  logic [REG_W-1:0]         reg_addr_reg, reg_addr_next;
  logic [pBYTECNT_SIZE-1:0] len_reg, bytecnt_reg, bytecnt_next;
  logic                     timer_load, timer_expired;
  logic [TW-1:0]            timer_val;
  logic                     accept, wdata_hs, capture, hold_release, hold_exit;
  logic                     last_byte, burst_end, bus_active, phase_entry;

  logic                     cmd_ready_reg, wdata_ready_reg, rdata_valid_reg, done_reg;
  logic                     usb_data_oe_reg, usb_rdn_reg, usb_wrn_reg, usb_cen_reg;
  logic [7:0]               rdata_reg, usb_dout_reg;
  logic [pADDR_WIDTH-1:0]   usb_addr_reg;

  assign accept        = (state_reg == ST_IDLE) && cmd_ready_reg && cmd_valid;
  assign wdata_hs      = (state_reg == ST_WDATA) && wdata_valid;
  assign capture       = (state_reg == ST_STROBE) && timer_expired && !write_reg;
  // A read byte must be consumed before the hold phase may end.
  assign hold_release  = write_reg || !rdata_valid_reg || rdata_ready;
  assign hold_exit     = (state_reg == ST_HOLD) && timer_expired && hold_release;
  assign last_byte     = (bytecnt_reg == len_reg);
  assign burst_end     = hold_exit && last_byte;
  assign write_next    = accept ? cmd_write : write_reg;
  assign reg_addr_next = accept ? cmd_reg : reg_addr_reg;
  assign phase_entry   = (state_next != state_reg);
  assign bus_active    = (state_next == ST_SETUP) || (state_next == ST_STROBE) ||
                         (state_next == ST_HOLD);

  // State register.
  always_ff @(posedge usb_clk or posedge reset_i) begin
    if (reset_i) state_reg <= ST_IDLE;
    else         state_reg <= state_next;
  end

  // Next-state and byte-counter logic; terminal compare comes before the increment.
  always_comb begin
    state_next   = state_reg;
    bytecnt_next = bytecnt_reg;
    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          bytecnt_next = '0;
          state_next   = cmd_write ? ST_WDATA : ST_SETUP;
        end
      end
      ST_WDATA:  if (wdata_hs) state_next = ST_SETUP;
      ST_SETUP:  if (timer_expired) state_next = ST_STROBE;
      ST_STROBE: if (timer_expired) state_next = ST_HOLD;
      ST_HOLD: begin
        if (hold_exit) begin
          if (last_byte) begin
            state_next = ST_IDLE;
          end else begin
            bytecnt_next = bytecnt_reg + pBYTECNT_SIZE'(1);
            state_next   = write_reg ? ST_WDATA : ST_SETUP;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Phase length selection, loaded whenever a new state is entered.
  always_comb begin
    timer_load = phase_entry;
    timer_val  = '0;
    case (state_next)
      ST_SETUP:  timer_val = TW'(pSETUP_CYCLES - 1);
      ST_STROBE: timer_val = TW'(pSTROBE_CYCLES - 1);
      ST_HOLD:   timer_val = TW'(pHOLD_CYCLES - 1);
      default:   timer_val = '0;
    endcase
  end

  cw305_bus_phase_timer #(.pWIDTH(TW)) u_phase_timer (
    .clk      (usb_clk),
    .rst      (reset_i),
    .load     (timer_load),
    .load_val (timer_val),
    .expired  (timer_expired)
  );

  // Command latches and byte counter.
  always_ff @(posedge usb_clk or posedge reset_i) begin
    if (reset_i) begin
      write_reg    <= 1'b0;
      reg_addr_reg <= '0;
      len_reg      <= '0;
      bytecnt_reg  <= '0;
    end else begin
      if (accept) begin
        write_reg    <= cmd_write;
        reg_addr_reg <= cmd_reg;
        len_reg      <= cmd_len;
      end
      bytecnt_reg <= bytecnt_next;
    end
  end

  // Registered outputs, derived from the state being entered so pins change on the edge.
  always_ff @(posedge usb_clk or posedge reset_i) begin
    if (reset_i) begin
      cmd_ready_reg   <= 1'b1;
      wdata_ready_reg <= 1'b0;
      done_reg        <= 1'b0;
      usb_cen_reg     <= 1'b1;
      usb_data_oe_reg <= 1'b0;
      usb_wrn_reg     <= 1'b1;
      usb_rdn_reg     <= 1'b1;
      usb_dout_reg    <= '0;
      usb_addr_reg    <= '0;
      rdata_reg       <= '0;
      rdata_valid_reg <= 1'b0;
    end else begin
      // Hold off a new command during the done cycle.
      cmd_ready_reg   <= (state_next == ST_IDLE) && !burst_end;
      wdata_ready_reg <= (state_next == ST_WDATA);
      done_reg        <= burst_end;
      usb_cen_reg     <= !bus_active;
      usb_data_oe_reg <= bus_active && write_next;
      usb_wrn_reg     <= !((state_next == ST_STROBE) && write_next);
      usb_rdn_reg     <= !((state_next == ST_STROBE) && !write_next);
      if (wdata_hs) usb_dout_reg <= wdata;
      if ((state_next == ST_SETUP) && phase_entry) begin
        usb_addr_reg <= pADDR_WIDTH'(bus_addr(64'(reg_addr_next), 64'(bytecnt_next), pBYTECNT_SIZE));
      end
      if (capture) begin
        rdata_reg       <= usb_din;
        rdata_valid_reg <= 1'b1;
      end else if (rdata_valid_reg && rdata_ready) begin
        rdata_valid_reg <= 1'b0;
      end
    end
  end

  assign cmd_ready   = cmd_ready_reg;
  assign wdata_ready = wdata_ready_reg;
  assign rdata_valid = rdata_valid_reg;
  assign rdata       = rdata_reg;
  assign done        = done_reg;
  assign usb_addr    = usb_addr_reg;
  assign usb_dout    = usb_dout_reg;
  assign usb_data_oe = usb_data_oe_reg;
  assign usb_rdn     = usb_rdn_reg;
  assign usb_wrn     = usb_wrn_reg;
  assign usb_cen     = usb_cen_reg;

endmodule

// File: tb/tb_cw305_usb_bus_master.sv
// Self-checking bench for cw305_usb_bus_master: directed test-plan bursts plus random bursts.
module tb_cw305_usb_bus_master;

  localparam int AW = 21;
  localparam int BW = 8;
  localparam int RW = AW - BW;
  localparam int S  = 1;
  localparam int T  = 3;
  localparam int H  = 1;

  logic          usb_clk = 1'b0;
  logic          reset_i = 1'b1;
  logic          cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [RW-1:0] cmd_reg = '0;
  logic [BW-1:0] cmd_len = '0;
  logic          wdata_valid = 1'b0, wdata_ready;
  logic [7:0]    wdata = '0;
  logic          rdata_valid, rdata_ready = 1'b1;
  logic [7:0]    rdata;
  logic          done;
  logic [AW-1:0] usb_addr;
  logic [7:0]    usb_dout, usb_din;
  logic          usb_data_oe, usb_rdn, usb_wrn, usb_cen;

  int total = 0;
  int bad   = 0;

  always #5 usb_clk = ~usb_clk;

  // Responder: byte index ^ 0xA5 while the read strobe is low, junk otherwise.
  assign usb_din = !usb_rdn ? (usb_addr[7:0] ^ 8'hA5) : 8'h5A;

  cw305_usb_bus_master #(
    .pADDR_WIDTH(AW), .pBYTECNT_SIZE(BW),
    .pSETUP_CYCLES(S), .pSTROBE_CYCLES(T), .pHOLD_CYCLES(H)
  ) dut (
    .usb_clk(usb_clk), .reset_i(reset_i),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_reg(cmd_reg), .cmd_len(cmd_len),
    .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
    .rdata_valid(rdata_valid), .rdata_ready(rdata_ready), .rdata(rdata),
    .done(done), .usb_addr(usb_addr), .usb_dout(usb_dout), .usb_data_oe(usb_data_oe),
    .usb_din(usb_din), .usb_rdn(usb_rdn), .usb_wrn(usb_wrn), .usb_cen(usb_cen)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Bus monitor: logs every strobe and counts events and protocol violations.
  logic [AW-1:0] mon_addr_q[$];
  logic [7:0]    mon_data_q[$];
  int            mon_len_q[$];
  bit            mon_wr_q[$];
  bit            mon_stable_q[$];
  int            done_cnt = 0, rvalid_cnt = 0, viol_cnt = 0, low_cnt = 0;
  bit            low_wr = 1'b0, st_stable = 1'b0;
  logic [AW-1:0] st_addr = '0;
  logic [7:0]    st_dout = '0;

  always @(negedge usb_clk) begin
    if (done) done_cnt++;
    if (rdata_valid) rvalid_cnt++;
    if ((!usb_rdn && !usb_wrn) || (!usb_rdn && usb_data_oe) ||
        (!usb_wrn && (usb_cen || !usb_data_oe)) || (wdata_ready && !usb_cen))
      viol_cnt++;
    if (!usb_rdn || !usb_wrn) begin
      if (low_cnt == 0) begin
        st_addr = usb_addr; st_dout = usb_dout; st_stable = 1'b1; low_wr = !usb_wrn;
      end else if (usb_addr !== st_addr || (low_wr && usb_dout !== st_dout)) begin
        st_stable = 1'b0;
      end
      low_cnt++;
    end else if (low_cnt != 0) begin
      mon_addr_q.push_back(st_addr);
      mon_data_q.push_back(st_dout);
      mon_len_q.push_back(low_cnt);
      mon_wr_q.push_back(low_wr);
      mon_stable_q.push_back(st_stable);
      low_cnt = 0;
    end
  end

  // One burst: issue, feed/drain bytes, then compare the bus log against the expected burst.
  task automatic run_burst(input bit wr, input logic [RW-1:0] rg, input logic [7:0] len,
                           input int stall_byte, input int stall_len, input int reset_byte,
                           input bit hold_cmd, input bit pat);
    logic [7:0] wbytes[256];
    int  qb, db, vb, rv, widx, ridx, gap, cycles, n, nbytes;
    bit  hs_w, hs_r, aborted, timeout;
    nbytes = int'(len) + 1;
    for (int i = 0; i < 256; i++) wbytes[i] = pat ? 8'((i + 1) * 17) : 8'($urandom);
    qb = mon_addr_q.size(); db = done_cnt; vb = viol_cnt;
    @(negedge usb_clk);
    cmd_valid = 1'b1; cmd_write = wr; cmd_reg = rg; cmd_len = len;
    n = 0;
    while (!cmd_ready && n < 100) begin @(negedge usb_clk); n++; end
    if (!cmd_ready) begin
      check_val("cmd_accept_timeout", 32'(cmd_ready), 32'd1);
      cmd_valid = 1'b0;
      return;
    end
    @(posedge usb_clk);
    cycles = 0; widx = 0; ridx = 0; gap = 0; aborted = 0; timeout = 0;
    forever begin
      @(negedge usb_clk);
      if (!hold_cmd) cmd_valid = 1'b0;
      if (done) break;
      if (cycles > 4000) begin timeout = 1; break; end
      if (reset_byte >= 0 && (!usb_rdn || !usb_wrn) && usb_addr[7:0] == 8'(reset_byte)) begin
        reset_i = 1'b1;
        #1;
        check_val("rst_rdn", 32'(usb_rdn), 32'd1);
        check_val("rst_wrn", 32'(usb_wrn), 32'd1);
        check_val("rst_cen", 32'(usb_cen), 32'd1);
        check_val("rst_oe", 32'(usb_data_oe), 32'd0);
        aborted = 1;
        break;
      end
      wdata_valid = 1'b0;
      if (wr && widx < nbytes) begin
        if (widx == stall_byte && gap < stall_len) begin
          if (wdata_ready) begin gap++; check_val("cen_in_gap", 32'(usb_cen), 32'd1); end
        end else begin
          wdata_valid = 1'b1; wdata = wbytes[widx];
        end
      end
      hs_w = wdata_valid && wdata_ready;
      rdata_ready = 1'b1;
      if (!wr && rdata_valid && ridx == stall_byte && gap < stall_len) begin
        rdata_ready = 1'b0; gap++;
        check_val("rdn_in_stall", 32'(usb_rdn), 32'd1);
      end
      hs_r = rdata_valid && rdata_ready;
      if (hs_r) check_val($sformatf("rdata[%0d]", ridx), 32'(rdata), 32'(8'(ridx) ^ 8'hA5));
      @(posedge usb_clk);
      cycles++;
      if (hs_w) widx++;
      if (hs_r) ridx++;
    end
    cmd_valid = 1'b0; wdata_valid = 1'b0; rdata_ready = 1'b1;
    $display("burst wr=%0d reg=%0h len=%0d cycles=%0d aborted=%0d", wr, rg, len, cycles, aborted);
    if (timeout) begin
      check_val("burst_timeout", 32'd1, 32'd0);
      return;
    end
    if (aborted) begin
      repeat (2) @(negedge usb_clk);
      reset_i = 1'b0;
      rv = rvalid_cnt;
      repeat (20) @(negedge usb_clk);
      check_val("no_done_after_reset", 32'(done_cnt - db), 32'd0);
      check_val("no_rvalid_after_reset", 32'(rvalid_cnt - rv), 32'd0);
      check_val("ready_after_reset", 32'(cmd_ready), 32'd1);
      return;
    end
    check_val("ready_low_at_done", 32'(cmd_ready), 32'd0);
    if (stall_len == 0)
      check_val("burst_cycles", 32'(cycles), 32'(nbytes * ((wr ? 1 : 0) + S + T + H)));
    @(negedge usb_clk);
    check_val("ready_after_done", 32'(cmd_ready), 32'd1);
    repeat (3) @(negedge usb_clk);
    check_val("done_count", 32'(done_cnt - db), 32'd1);
    check_val("strobe_count", 32'(mon_addr_q.size() - qb), 32'(nbytes));
    check_val(wr ? "write_count" : "read_count", 32'(wr ? widx : ridx), 32'(nbytes));
    check_val("bus_invariants", 32'(viol_cnt - vb), 32'd0);
    for (int i = 0; i < nbytes && qb + i < mon_addr_q.size(); i++) begin
      check_val($sformatf("addr[%0d]", i), 32'(mon_addr_q[qb + i]), 32'({rg, 8'(i)}));
      check_val($sformatf("kind[%0d]", i), 32'(mon_wr_q[qb + i]), 32'(wr));
      check_val($sformatf("strobe_len[%0d]", i), 32'(mon_len_q[qb + i]), 32'(T));
      check_val($sformatf("stable[%0d]", i), 32'(mon_stable_q[qb + i]), 32'd1);
      if (wr) check_val($sformatf("wbyte[%0d]", i), 32'(mon_data_q[qb + i]), 32'(wbytes[i]));
    end
  endtask

  initial begin
    int sb;
    int sl;
    repeat (3) @(negedge usb_clk);
    check_val("reset_cen", 32'(usb_cen), 32'd1);
    check_val("reset_rdn", 32'(usb_rdn), 32'd1);
    check_val("reset_wrn", 32'(usb_wrn), 32'd1);
    check_val("reset_oe", 32'(usb_data_oe), 32'd0);
    check_val("reset_cmd_ready", 32'(cmd_ready), 32'd1);
    reset_i = 1'b0;
    @(negedge usb_clk);
    check_val("reset_addr", 32'(usb_addr), 32'd0);
    check_val("reset_dout", 32'(usb_dout), 32'd0);
    check_val("reset_rdata", 32'(rdata), 32'd0);
    check_val("reset_rvalid", 32'(rdata_valid), 32'd0);
    check_val("reset_wready", 32'(wdata_ready), 32'd0);
    check_val("reset_done", 32'(done), 32'd0);

    run_burst(1'b1, RW'(5), 8'd3, -1, 0, -1, 1'b1, 1'b1);         // 0x11..0x44 to reg 5
    run_burst(1'b0, RW'(6), 8'd31, -1, 0, -1, 1'b0, 1'b0);        // 32-byte read
    run_burst(1'b0, RW'(6), 8'd7, 2, 10, -1, 1'b0, 1'b0);         // rdata_ready stall on byte 2
    run_burst(1'b1, RW'(9), 8'd7, 3, 5, -1, 1'b0, 1'b0);          // wdata gap of 5 cycles
    run_burst(1'b0, RW'(13'h1abc), 8'd255, -1, 0, -1, 1'b0, 1'b0); // 256-byte read
    run_burst(1'b0, RW'(7), 8'd7, -1, 0, 3, 1'b0, 1'b0);          // reset in read strobe of byte 3
    run_burst(1'b1, RW'(8), 8'd5, -1, 0, -1, 1'b0, 1'b0);
    run_burst(1'b1, RW'(7), 8'd7, -1, 0, 3, 1'b0, 1'b0);          // reset in write strobe of byte 3
    run_burst(1'b0, RW'(3), 8'd4, -1, 0, -1, 1'b0, 1'b0);

    for (int k = 0; k < 12; k++) begin
      sb = -1; sl = 0;
      if ($urandom_range(0, 1) == 1) begin
        sb = int'($urandom_range(0, 4));
        sl = int'($urandom_range(1, 8));
      end
      run_burst(1'($urandom), RW'($urandom), 8'($urandom_range(0, 15)), sb, sl, -1,
                1'($urandom), 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
